// File: rtl/aoi211_sweep_ctrl.sv
// Sweep sequencer for an AOI211 cell: walks the 16 input vectors, samples ZN after
// a settle window and records the mismatch count and the first failing vector.
module aoi211_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       zn_in,
   output logic       a,
   output logic       b,
   output logic       c1,
   output logic       c2,
   output logic       busy,
   output logic       sample_strobe,
   output logic       vec_fail,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [3:0] first_fail,
   output logic       fail_valid,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_vec, w_vec_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic [3:0] r_drv, w_drv_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_vec_fail, w_vec_fail_nxt;
   logic       r_done, w_done_nxt;
   logic [4:0] r_err, w_err_nxt;
   logic [3:0] r_first, w_first_nxt;
   logic       r_fail_valid, w_fail_valid_nxt;

   logic w_strobe;
   logic w_exp_zn;
   logic w_mismatch;

   // r_drv is {a, b, c1, c2}; the golden ZN is computed from what is actually driven
   assign w_strobe   = (r_state == ST_RUN) && (r_cnt == 8'd1);
   assign w_exp_zn   = ~((r_drv[1] & r_drv[0]) | r_drv[2] | r_drv[3]);
   assign w_mismatch = w_strobe && (zn_in != w_exp_zn);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_vec        <= 4'd0;
         r_cnt        <= 8'd0;
         r_drv        <= 4'd0;
         r_busy       <= 1'b0;
         r_vec_fail   <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 5'd0;
         r_first      <= 4'd0;
         r_fail_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_vec        <= w_vec_nxt;
         r_cnt        <= w_cnt_nxt;
         r_drv        <= w_drv_nxt;
         r_busy       <= w_busy_nxt;
         r_vec_fail   <= w_vec_fail_nxt;
         r_done       <= w_done_nxt;
         r_err        <= w_err_nxt;
         r_first      <= w_first_nxt;
         r_fail_valid <= w_fail_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (abort)      w_state_nxt = ST_IDLE;
            else if (start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (abort)                              w_state_nxt = ST_IDLE;
            else if (w_strobe && (r_vec == 4'd15))  w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_vec_nxt        = r_vec;
      w_cnt_nxt        = r_cnt;
      w_drv_nxt        = r_drv;
      w_busy_nxt       = r_busy;
      w_vec_fail_nxt   = 1'b0;
      w_done_nxt       = r_done;
      w_err_nxt        = r_err;
      w_first_nxt      = r_first;
      w_fail_valid_nxt = r_fail_valid;
      if (r_state != ST_RUN) begin
         if (abort) begin
            w_done_nxt = 1'b0;
         end else if (start) begin
            w_vec_nxt        = 4'd0;
            w_drv_nxt        = 4'd0;
            w_err_nxt        = 5'd0;
            w_first_nxt      = 4'd0;
            w_fail_valid_nxt = 1'b0;
            w_done_nxt       = 1'b0;
            w_busy_nxt       = 1'b1;
            w_cnt_nxt        = SETTLE;
         end
      end else if (abort) begin
         // a sample due at this edge is dropped; partial results are kept
         w_busy_nxt = 1'b0;
         w_drv_nxt  = 4'd0;
      end else if (r_cnt > 8'd1) begin
         w_cnt_nxt = r_cnt - 8'd1;
      end else begin
         if (w_mismatch) begin
            w_err_nxt      = r_err + 5'd1;
            w_vec_fail_nxt = 1'b1;
            if (!r_fail_valid) begin
               w_first_nxt      = r_vec;
               w_fail_valid_nxt = 1'b1;
            end
         end
         if (r_vec != 4'd15) begin
            w_vec_nxt = r_vec + 4'd1;
            w_drv_nxt = r_vec + 4'd1;
            w_cnt_nxt = SETTLE;
         end else begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
            w_drv_nxt  = 4'd0;
         end
      end
   end

   assign {a, b, c1, c2}  = r_drv;
   assign busy            = r_busy;
   assign sample_strobe   = w_strobe;
   assign vec_fail        = r_vec_fail;
   assign done            = r_done;
   assign pass            = r_done && (r_err == 5'd0);
   assign err_count       = r_err;
   assign first_fail      = r_first;
   assign fail_valid      = r_fail_valid;
   assign dbg_state       = r_state;

endmodule

// File: tb/tb_aoi211_sweep_ctrl.sv
// Bench for aoi211_sweep_ctrl: a behavioural cell (correct / stuck-at-0 / stuck-at-1)
// on zn_in, a table of full sweeps, and hand sequences for abort, restart and reset.
module tb_aoi211_sweep_ctrl;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst, start, abort, zn_in;
   logic       a, b, c1, c2, busy, sample_strobe, vec_fail, done, pass, fail_valid;
   logic [4:0] err_count;
   logic [3:0] first_fail;
   logic [1:0] dbg_state;

   aoi211_sweep_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .zn_in(zn_in),
      .a(a), .b(b), .c1(c1), .c2(c2), .busy(busy), .sample_strobe(sample_strobe),
      .vec_fail(vec_fail), .done(done), .pass(pass), .err_count(err_count),
      .first_fail(first_fail), .fail_valid(fail_valid), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // cell under test: 0 = correct AOI211, 1 = ZN stuck at 0, 2 = ZN stuck at 1
   int tb_mode = 0;
   always_comb begin
      case (tb_mode)
         1:       zn_in = 1'b0;
         2:       zn_in = 1'b1;
         default: zn_in = ~((c1 & c2) | b | a);
      endcase
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic mism(input logic [3:0] v, input int mode);
      logic g, z;
      g = ~((v[1] & v[0]) | v[2] | v[3]);
      z = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : g;
      return z != g;
   endfunction

   // scoreboard: vector indices expected at each sample strobe, in order
   logic [3:0] exp_q[$];
   logic       mon_en = 1'b0;
   logic       exp_vf = 1'b0;
   int         fail_pulses = 0;

   always @(negedge clk) begin
      if (vec_fail) fail_pulses++;
      if (mon_en) begin
         chk("vec_fail", int'(vec_fail), int'(exp_vf));
         exp_vf = 1'b0;
         if (sample_strobe) begin
            if (exp_q.size() == 0) chk("sample_extra", exp_q.size(), 1);
            else begin
               logic [3:0] k;
               k = exp_q.pop_front();
               chk("sample_vec", int'({a, b, c1, c2}), int'(k));
               exp_vf = mism(k, tb_mode);
            end
         end
      end
   end

   task automatic run_sweep(input int mode, input logic mon);
      mon_en = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
      exp_vf      = 1'b0;
      fail_pulses = 0;
      tb_mode     = mode;
      start       = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      mon_en = mon;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_vec(input logic [3:0] v, input logic need_strobe, output int n);
      n = 0;
      while (!(({a, b, c1, c2} == v) && (sample_strobe || !need_strobe)) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("wait_vec_timeout", int'(n < 400), 1);
   endtask

   typedef struct {
      int mode;
      int exp_err;
      int exp_first;
      int exp_fv;
      int exp_pass;
   } sweep_t;

   sweep_t tbl[3];

   initial begin
      int n;
      tbl[0] = '{mode: 0, exp_err: 0,  exp_first: 0, exp_fv: 0, exp_pass: 1};
      tbl[1] = '{mode: 1, exp_err: 3,  exp_first: 0, exp_fv: 1, exp_pass: 0};
      tbl[2] = '{mode: 2, exp_err: 13, exp_first: 3, exp_fv: 1, exp_pass: 0};

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_drive", int'({a, b, c1, c2}), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_err", int'(err_count), 0);
      chk("rst_fv", int'(fail_valid), 0);
      chk("rst_strobe", int'(sample_strobe), 0);
      chk("rst_state", int'(dbg_state), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 3; t++) begin
         run_sweep(tbl[t].mode, 1'b1);
         chk("start_busy", int'(busy), 1);
         chk("start_drive", int'({a, b, c1, c2}), 0);
         wait_done(n);
         chk("done_latency", n, 16 * SETTLE);
         chk("sweep_err", int'(err_count), tbl[t].exp_err);
         chk("sweep_first", int'(first_fail), tbl[t].exp_first);
         chk("sweep_fv", int'(fail_valid), tbl[t].exp_fv);
         chk("sweep_pass", int'(pass), tbl[t].exp_pass);
         chk("sweep_drive", int'({a, b, c1, c2}), 0);
         chk("sweep_busy", int'(busy), 0);
         @(negedge clk);
         chk("sweep_pulses", fail_pulses, tbl[t].exp_err);
         chk("sweep_q_empty", exp_q.size(), 0);
         chk("done_held", int'(done), 1);
      end

      // start in RUN is ignored; restart from DONE clears results (stuck-1 left 13)
      run_sweep(0, 1'b1);
      chk("restart_err_clr", int'(err_count), 0);
      chk("restart_done_clr", int'(done), 0);
      wait_vec(4'd7, 1'b0, n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("repulse_err", int'(err_count), 0);
      chk("repulse_pass", int'(pass), 1);
      chk("repulse_q_empty", exp_q.size(), 0);
      @(negedge clk);
      run_sweep(1, 1'b1);
      chk("restart2_pass_clr", int'(pass), 0);
      wait_done(n);
      chk("restart2_latency", n, 16 * SETTLE);
      chk("restart2_err", int'(err_count), 3);
      chk("restart2_first", int'(first_fail), 0);

      // abort in DONE: back to IDLE with results held; abort beats start in IDLE
      @(negedge clk);
      mon_en = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      chk("abort_done_state", int'(dbg_state), 0);
      chk("abort_done_done", int'(done), 0);
      chk("abort_done_err", int'(err_count), 3);
      chk("abort_done_pass", int'(pass), 0);
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_start_state", int'(dbg_state), 0);
      chk("abort_start_busy", int'(busy), 0);

      // abort during vector 5's sample cycle, stuck-1 cell: vectors 3,4 count, 5 is dropped
      run_sweep(2, 1'b0);
      wait_vec(4'd5, 1'b1, n);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_state", int'(dbg_state), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_drive", int'({a, b, c1, c2}), 0);
      chk("abort_err", int'(err_count), 2);
      chk("abort_first", int'(first_fail), 3);
      chk("abort_fv", int'(fail_valid), 1);
      chk("abort_vec_fail", int'(vec_fail), 0);
      repeat (4) @(negedge clk);
      chk("abort_stays_idle", int'(dbg_state), 0);

      // rst mid-sweep with abort and start high: everything clears
      run_sweep(1, 1'b0);
      wait_vec(4'd9, 1'b0, n);
      rst = 1'b1; abort = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; abort = 1'b0; start = 1'b0;
      chk("mrst_drive", int'({a, b, c1, c2}), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_err", int'(err_count), 0);
      chk("mrst_fv", int'(fail_valid), 0);
      chk("mrst_first", int'(first_fail), 0);
      chk("mrst_state", int'(dbg_state), 0);
      @(negedge clk);
      run_sweep(0, 1'b1);
      wait_done(n);
      chk("post_rst_latency", n, 16 * SETTLE);
      chk("post_rst_pass", int'(pass), 1);
      @(negedge clk);
      chk("post_rst_q_empty", exp_q.size(), 0);
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
